stopwatch_ctrl: RTL and testbench

- Consumes the three one-cycle, debounced button pulses produced by the 40 Hz chatter-removal stage.
- Implements a stopwatch with start/stop, lap-freeze and clear functions, counting in 1/100 s.
- Drives 6 BCD digits (MM:SS.cc) to the downstream 7-segment display driver.
- Sits between the button conditioning stage and the display multiplexer, on the 50 MHz system clock.

---
 rtl/stopwatch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop, lap-freeze and clear on debounced button pulses; MM:SS.cc BCD out.
// Latency: DISP/RUNNING/LAPPED/WRAP are registered, valid the cycle after the deciding CLK edge.
// Backpressure: none; button pulses are single-cycle events consumed on the edge they arrive.
//
// Ports:
//   CLK      system clock (50 MHz)
//   RST      synchronous active-high reset, highest priority
//   BIN[2:0] one-cycle button pulses: [0] start/stop, [1] lap, [2] clear
//   DISP     6 BCD digits, MSB first: min tens, min ones, sec tens, sec ones, 1/10 s, 1/100 s
//   RUNNING  high while counting (RUN or LAP)
//   LAPPED   high in LAP; DISP is frozen on the lap register
//   WRAP     one-cycle pulse after the count rolls 59:59.99 -> 00:00.00
module stopwatch_ctrl #(
    parameter int unsigned CLK_DIV = 500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  BIN,
    output logic [23:0] DISP,
    output logic        RUNNING,
    output logic        LAPPED,
    output logic        WRAP
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2,
        S_LAP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [23:0]    live_q, live_d;
    logic [23:0]    lap_q, lap_d;
    logic [23:0]    disp_q, disp_d;
    logic           running_q, running_d;
    logic           lapped_q, lapped_d;
    logic           wrap_q, wrap_d;

    logic           counting;
    logic           tick;
    logic           clear;
    logic [23:0]    live_inc;
    logic           c0, c1, c2, c3, c4, c5;

    // One BCD digit step. Any value at or above the digit limit rolls to 0
    // with carry, so a corrupted digit can never persist as non-BCD.
    function automatic logic [4:0] bcd_inc(input logic [3:0] dig,
                                           input logic [3:0] max_v,
                                           input logic       cin);
        logic [4:0] res;
        if (!cin) begin
            res = {1'b0, dig};
        end else if (dig >= max_v) begin
            res = {1'b1, 4'd0};
        end else begin
            res = {1'b0, dig + 4'd1};
        end
        return res;
    endfunction

    // Full ripple increment of the live count; applied only on tick.
    always_comb begin
        {c0, live_inc[3:0]}   = bcd_inc(live_q[3:0],   4'd9, 1'b1);
        {c1, live_inc[7:4]}   = bcd_inc(live_q[7:4],   4'd9, c0);
        {c2, live_inc[11:8]}  = bcd_inc(live_q[11:8],  4'd9, c1);
        {c3, live_inc[15:12]} = bcd_inc(live_q[15:12], 4'd5, c2);
        {c4, live_inc[19:16]} = bcd_inc(live_q[19:16], 4'd9, c3);
        {c5, live_inc[23:20]} = bcd_inc(live_q[23:20], 4'd5, c4);
    end

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);
    assign tick     = counting && (presc_q == PRESC_MAX);
    assign clear    = (state_q == S_STOP) && BIN[2];

    // Next-state: buttons not listed for a state are ignored; earlier
    // entries in each branch win on simultaneous pulses.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (BIN[0]) state_d = S_RUN;
            end
            S_RUN: begin
                if (BIN[0])      state_d = S_STOP;
                else if (BIN[1]) state_d = S_LAP;
            end
            S_LAP: begin
                if (BIN[0])      state_d = S_STOP;
                else if (BIN[1]) state_d = S_RUN;
            end
            S_STOP: begin
                if (BIN[2])      state_d = S_IDLE;
                else if (BIN[0]) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        // Prescaler holds in STOP so a resume keeps the sub-tick phase;
        // it is zeroed both in IDLE and on the edge that enters IDLE.
        presc_d = presc_q;
        if ((state_q == S_IDLE) || (state_d == S_IDLE)) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        // A tick on the edge that leaves RUN/LAP is still applied.
        live_d = live_q;
        if (clear) begin
            live_d = '0;
        end else if (tick) begin
            live_d = live_inc;
        end

        // Entering LAP captures the pre-increment count, i.e. what DISP
        // shows during the cycle the lap button is pressed.
        lap_d = lap_q;
        if (clear) begin
            lap_d = '0;
        end else if ((state_q == S_RUN) && (state_d == S_LAP)) begin
            lap_d = live_q;
        end

        disp_d    = (state_d == S_LAP) ? lap_d : live_d;
        running_d = (state_d == S_RUN) || (state_d == S_LAP);
        lapped_d  = (state_d == S_LAP);
        wrap_d    = tick && c5;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            live_q    <= '0;
            lap_q     <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            lapped_q  <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            live_q    <= live_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lapped_q  <= lapped_d;
            wrap_q    <= wrap_d;
        end
    end

    assign DISP    = disp_q;
    assign RUNNING = running_q;
    assign LAPPED  = lapped_q;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV = 4 (one tick every 4 counting cycles).
// Inputs change and outputs are sampled on the falling edge.
// Long counts are preloaded by forcing the live count while stopped.
module tb_stopwatch_ctrl;

    localparam int unsigned DIV = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  bin;
    logic [23:0] disp;
    logic        running;
    logic        lapped;
    logic        wrap;

    int tests_run;
    int tests_failed;

    stopwatch_ctrl #(.CLK_DIV(DIV)) dut (
        .CLK     (clk),
        .RST     (rst),
        .BIN     (bin),
        .DISP    (disp),
        .RUNNING (running),
        .LAPPED  (lapped),
        .WRAP    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, ending on a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle button pulse across exactly one rising edge.
    task automatic pulse(input logic [2:0] b);
        bin = b;
        @(negedge clk);
        bin = 3'b000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bin = 3'b000;
        step(2);
        rst = 1'b0;
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0 || lapped !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_init: disp=%h run=%b lap=%b wrap=%b, want 000000 0 0 0",
                     disp, running, lapped, wrap);
        end
    endtask

    task automatic test_start_stop;
        logic held;
        pulse(3'b001);
        tests_run++;
        if (running !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_running: got %b want 1", running);
        end
        step(40);
        tests_run++;
        if (disp !== 24'h000010) begin
            tests_failed++;
            $display("FAIL run_40_cycles: got %h want 000010", disp);
        end
        pulse(3'b001);
        tests_run++;
        if (running !== 1'b0 || disp !== 24'h000010) begin
            tests_failed++;
            $display("FAIL stop: run=%b disp=%h want 0 000010", running, disp);
        end
        held = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (disp !== 24'h000010) held = 1'b0;
        end
        tests_run++;
        if (held !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_hold: disp moved, now %h want 000010", disp);
        end
        // Stopped with prescaler at 1: resume needs only 3 edges to tick.
        pulse(3'b001);
        step(2);
        tests_run++;
        if (disp !== 24'h000010) begin
            tests_failed++;
            $display("FAIL resume_phase_early: got %h want 000010", disp);
        end
        step(1);
        tests_run++;
        if (disp !== 24'h000011) begin
            tests_failed++;
            $display("FAIL resume_phase_tick: got %h want 000011", disp);
        end
    endtask

    task automatic test_lap;
        pulse(3'b001);
        pulse(3'b100);
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL lap_prep_clear: disp=%h run=%b want 000000 0", disp, running);
        end
        pulse(3'b001);
        step(20);
        pulse(3'b010);
        tests_run++;
        if (disp !== 24'h000005 || lapped !== 1'b1 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL lap_enter: disp=%h lap=%b run=%b want 000005 1 1", disp, lapped, running);
        end
        step(20);
        tests_run++;
        if (disp !== 24'h000005) begin
            tests_failed++;
            $display("FAIL lap_frozen: got %h want 000005", disp);
        end
        pulse(3'b010);
        tests_run++;
        if (disp !== 24'h000010 || lapped !== 1'b0 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL lap_exit: disp=%h lap=%b run=%b want 000010 0 1", disp, lapped, running);
        end
    endtask

    task automatic test_clear;
        // RUN at 00:00.10, prescaler 2.
        pulse(3'b100);
        tests_run++;
        if (running !== 1'b1 || disp !== 24'h000010) begin
            tests_failed++;
            $display("FAIL clear_in_run: run=%b disp=%h want 1 000010", running, disp);
        end
        // Prescaler now 3: the stop edge coincides with a tick, which still counts.
        pulse(3'b001);
        tests_run++;
        if (running !== 1'b0 || disp !== 24'h000011) begin
            tests_failed++;
            $display("FAIL stop_on_tick: run=%b disp=%h want 0 000011", running, disp);
        end
        pulse(3'b100);
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_in_stop: disp=%h run=%b want 000000 0", disp, running);
        end
        pulse(3'b001);
        step(6);
        pulse(3'b001);
        tests_run++;
        if (disp !== 24'h000001) begin
            tests_failed++;
            $display("FAIL clear_prep: got %h want 000001", disp);
        end
        pulse(3'b101);
        step(2);
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_beats_start: disp=%h run=%b want 000000 0", disp, running);
        end
    endtask

    task automatic test_simultaneous;
        pulse(3'b001);
        step(4);
        pulse(3'b011);
        tests_run++;
        if (running !== 1'b0 || lapped !== 1'b0 || disp !== 24'h000001) begin
            tests_failed++;
            $display("FAIL start_beats_lap: run=%b lap=%b disp=%h want 0 0 000001",
                     running, lapped, disp);
        end
        // Resume with prescaler 1; after two edges it sits at 3, so the lap edge ticks.
        pulse(3'b001);
        step(2);
        pulse(3'b010);
        tests_run++;
        if (disp !== 24'h000001 || lapped !== 1'b1) begin
            tests_failed++;
            $display("FAIL lap_on_tick: disp=%h lap=%b want 000001 1", disp, lapped);
        end
        step(4);
        pulse(3'b010);
        tests_run++;
        if (disp !== 24'h000003 || lapped !== 1'b0) begin
            tests_failed++;
            $display("FAIL lap_on_tick_live: disp=%h lap=%b want 000003 0", disp, lapped);
        end
        pulse(3'b001);
        pulse(3'b100);
    endtask

    task automatic test_rollover;
        pulse(3'b001);
        pulse(3'b001);
        force dut.live_q = 24'h595999;
        step(1);
        release dut.live_q;
        step(1);
        tests_run++;
        if (disp !== 24'h595999 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL preload_595999: disp=%h run=%b want 595999 0", disp, running);
        end
        pulse(3'b001);
        step(2);
        tests_run++;
        if (disp !== 24'h595999 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_wrap: disp=%h wrap=%b want 595999 0", disp, wrap);
        end
        step(1);
        tests_run++;
        if (disp !== 24'h000000 || wrap !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_edge: disp=%h wrap=%b want 000000 1", disp, wrap);
        end
        step(1);
        tests_run++;
        if (wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_one_cycle: got %b want 0", wrap);
        end
        step(4);
        tests_run++;
        if (disp !== 24'h000001 || running !== 1'b1) begin
            tests_failed++;
            $display("FAIL count_after_wrap: disp=%h run=%b want 000001 1", disp, running);
        end
        // Carry 00:09.99 -> 00:10.00 (stopped with prescaler 2).
        pulse(3'b001);
        force dut.live_q = 24'h000999;
        step(1);
        release dut.live_q;
        step(1);
        pulse(3'b001);
        step(1);
        tests_run++;
        if (disp !== 24'h000999) begin
            tests_failed++;
            $display("FAIL carry_sec_before: got %h want 000999", disp);
        end
        step(1);
        tests_run++;
        if (disp !== 24'h001000) begin
            tests_failed++;
            $display("FAIL carry_sec: got %h want 001000", disp);
        end
        // Carry 09:59.99 -> 10:00.00 (stopped with prescaler 1).
        pulse(3'b001);
        force dut.live_q = 24'h095999;
        step(1);
        release dut.live_q;
        step(1);
        pulse(3'b001);
        step(3);
        tests_run++;
        if (disp !== 24'h100000 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_min: disp=%h wrap=%b want 100000 0", disp, wrap);
        end
    endtask

    task automatic test_reset_mid_run;
        // Still running at 10:00.00; reset discards everything.
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0 || lapped !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: disp=%h run=%b lap=%b wrap=%b want 000000 0 0 0",
                     disp, running, lapped, wrap);
        end
        step(20);
        tests_run++;
        if (disp !== 24'h000000 || running !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_advance: disp=%h run=%b want 000000 0", disp, running);
        end
        // Reset beats a simultaneous start pulse.
        rst = 1'b1;
        bin = 3'b001;
        step(1);
        rst = 1'b0;
        bin = 3'b000;
        tests_run++;
        if (running !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_priority: run=%b want 0", running);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        bin = 3'b000;
        test_reset();
        test_start_stop();
        test_lap();
        test_clear();
        test_simultaneous();
        test_rollover();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
